// File: rtl/be_stream_packer.sv
// Byte stream to wide RAM word packer: little-endian lane assembly,
// one registered byte-enabled write per completed or terminated word.
module be_stream_packer #(
   parameter int DWIDTH  = 128,
   parameter int AWIDTH  = 4,
   parameter int BEWIDTH = DWIDTH / 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic [7:0]         s_data,
   input  logic               s_valid,
   input  logic               s_last,
   output logic               s_ready,
   output logic               mem_we,
   output logic [AWIDTH-1:0]  mem_addr,
   output logic [DWIDTH-1:0]  mem_data,
   output logic [BEWIDTH-1:0] mem_be,
   output logic [AWIDTH:0]    word_cnt,
   output logic               full
);

   localparam int LW = (BEWIDTH > 1) ? $clog2(BEWIDTH) : 1;
   localparam logic [LW-1:0]     LANE_MAX = LW'(BEWIDTH - 1);
   localparam logic [LW-1:0]     LANE_ONE = LW'(1);
   localparam logic [AWIDTH-1:0] ADDR_ONE = AWIDTH'(1);
   localparam logic [AWIDTH:0]   CNT_ONE  = (AWIDTH + 1)'(1);

   logic [LW-1:0]      lane;
   logic [DWIDTH-1:0]  asm_data;
   logic [DWIDTH-1:0]  data_nx;
   logic [BEWIDTH-1:0] asm_be;
   logic [BEWIDTH-1:0] be_nx;
   logic [AWIDTH-1:0]  addr;
   logic               acc;
   logic               done;

   assign s_ready = !rst && !full && !clr;
   assign acc     = s_valid && s_ready;
   assign done    = acc && (s_last || lane == LANE_MAX);

   // Assembly contents with the incoming byte merged into the current lane
   always_comb begin
      data_nx = asm_data;
      be_nx   = asm_be;
      data_nx[int'(lane) * 8 +: 8] = s_data;
      be_nx[lane] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane     <= '0;
         asm_data <= '0;
         asm_be   <= '0;
         addr     <= '0;
         word_cnt <= '0;
         full     <= 1'b0;
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_data <= '0;
         mem_be   <= '0;
      end else if (clr) begin
         lane     <= '0;
         asm_data <= '0;
         asm_be   <= '0;
         addr     <= '0;
         word_cnt <= '0;
         full     <= 1'b0;
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_data <= '0;
         mem_be   <= '0;
      end else begin
         mem_we <= done;
         if (done) begin
            lane     <= '0;
            asm_data <= '0;
            asm_be   <= '0;
            mem_addr <= addr;
            mem_data <= data_nx;
            mem_be   <= be_nx;
            word_cnt <= word_cnt + CNT_ONE;
            // Last address staged: freeze instead of wrapping onto address 0
            if (&addr) full <= 1'b1;
            else addr <= addr + ADDR_ONE;
         end else if (acc) begin
            lane     <= lane + LANE_ONE;
            asm_data <= data_nx;
            asm_be   <= be_nx;
         end
      end
   end

endmodule

// File: tb/tb_be_stream_packer.sv
// Randomised bench for be_stream_packer against a queue-based word model,
// plus literal checks on the hand-computed write scenarios.
module tb_be_stream_packer;

   localparam int DW    = 128;
   localparam int AW    = 4;
   localparam int BEW   = DW / 8;
   localparam int DEPTH = 1 << AW;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           clr = 1'b0;
   logic [7:0]     s_data = '0;
   logic           s_valid = 1'b0;
   logic           s_last = 1'b0;
   logic           s_ready;
   logic           mem_we;
   logic [AW-1:0]  mem_addr;
   logic [DW-1:0]  mem_data;
   logic [BEW-1:0] mem_be;
   logic [AW:0]    word_cnt;
   logic           full;

   be_stream_packer #(.DWIDTH(DW), .AWIDTH(AW)) dut (
      .clk(clk), .rst(rst), .clr(clr),
      .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
      .s_ready(s_ready), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_data(mem_data), .mem_be(mem_be),
      .word_cnt(word_cnt), .full(full)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Model: bytes of the open word, next address, counters, visible write
   logic [7:0]     m_bytes[$];
   int             m_addr;
   int             m_cnt;
   int             m_accepted;
   bit             m_full;
   bit             e_we;
   logic [AW-1:0]  e_addr;
   logic [DW-1:0]  e_data;
   logic [BEW-1:0] e_be;

   task automatic chk(input string name, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_bytes.delete();
      m_addr = 0;
      m_cnt  = 0;
      m_full = 0;
      e_we   = 0;
      e_addr = '0;
      e_data = '0;
      e_be   = '0;
   endtask

   task automatic model_step(input bit v, input logic [7:0] d,
                             input bit l, input bit c);
      logic [DW-1:0] w;
      int n;
      if (c) begin
         model_reset();
         return;
      end
      e_we = 0;
      if (v && !m_full) begin
         m_accepted++;
         m_bytes.push_back(d);
         if (m_bytes.size() == BEW || l) begin
            w = '0;
            n = m_bytes.size();
            for (int i = 0; i < n; i++) w[i*8 +: 8] = m_bytes[i];
            e_we   = 1;
            e_addr = AW'(m_addr);
            e_data = w;
            e_be   = BEW'((32'd1 << n) - 1);
            m_cnt++;
            m_bytes.delete();
            if (m_addr == DEPTH - 1) m_full = 1;
            else m_addr++;
         end
      end
   endtask

   always @(negedge clk) begin
      chk("s_ready", DW'(s_ready), DW'(!rst && !m_full && !clr));
      chk("mem_we", DW'(mem_we), DW'(e_we));
      chk("mem_addr", DW'(mem_addr), DW'(e_addr));
      chk("mem_data", mem_data, e_data);
      chk("mem_be", DW'(mem_be), DW'(e_be));
      chk("word_cnt", DW'(word_cnt), DW'(m_cnt));
      chk("full", DW'(full), DW'(m_full));
   end

   task automatic tick(input bit v, input logic [7:0] d,
                       input bit l, input bit c);
      s_valid = v;
      s_data  = d;
      s_last  = l;
      clr     = c;
      @(posedge clk);
      model_step(v, d, l, c);
      #1;
   endtask

   task automatic idle();
      tick(0, 8'h00, 0, 0);
   endtask

   task automatic do_clr();
      tick(0, 8'h00, 0, 1);
   endtask

   initial begin
      int guard;
      model_reset();
      m_accepted = 0;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      #1 chk("ready_after_rst", DW'(s_ready), DW'(1));

      // 16 bytes 0x00..0x0F -> one full word at address 0
      for (int i = 0; i < 16; i++) tick(1, 8'(i), 0, 0);
      chk("t1_we", DW'(mem_we), DW'(1));
      chk("t1_addr", DW'(mem_addr), DW'(0));
      chk("t1_be", DW'(mem_be), DW'(16'hFFFF));
      chk("t1_data", mem_data, 128'h0F0E0D0C0B0A09080706050403020100);
      chk("t1_cnt", DW'(word_cnt), DW'(1));
      idle();

      // 5 bytes terminated by s_last, then next stream from lane 0
      for (int i = 0; i < 5; i++) tick(1, 8'hA1 + 8'(i), i == 4, 0);
      chk("t2_be", DW'(mem_be), DW'(16'h001F));
      chk("t2_data", mem_data, 128'hA5A4A3A2A1);
      chk("t2_addr", DW'(mem_addr), DW'(1));
      tick(1, 8'h5C, 1, 0);
      chk("t2_next_be", DW'(mem_be), DW'(16'h0001));
      chk("t2_next_addr", DW'(mem_addr), DW'(2));
      chk("t2_next_data", mem_data, 128'h5C);

      // Partial word discarded by clr
      do_clr();
      for (int i = 0; i < 7; i++) tick(1, 8'hE0 + 8'(i), 0, 0);
      do_clr();
      chk("t3_cnt", DW'(word_cnt), DW'(0));
      chk("t3_full", DW'(full), DW'(0));
      for (int i = 0; i < 16; i++) tick(1, 8'($urandom), 0, 0);
      chk("t3_addr", DW'(mem_addr), DW'(0));
      chk("t3_be", DW'(mem_be), DW'(16'hFFFF));

      // 256 bytes with random gaps fill the RAM
      do_clr();
      m_accepted = 0;
      guard = 0;
      while (m_accepted < 256 && guard < 3000) begin
         tick(($urandom % 4) != 0, 8'($urandom), 0, 0);
         guard++;
      end
      chk("t4_guard", DW'(m_accepted), DW'(256));
      chk("t4_full", DW'(full), DW'(1));
      chk("t4_ready", DW'(s_ready), DW'(0));
      chk("t4_cnt", DW'(word_cnt), DW'(16));
      chk("t4_addr", DW'(mem_addr), DW'(15));
      for (int i = 0; i < 10; i++) tick(1, 8'($urandom), i[0], 0);
      chk("t4_cnt_hold", DW'(word_cnt), DW'(16));

      // clr in the cycle that presents the write to address 3
      do_clr();
      for (int i = 0; i < 64; i++) tick(1, 8'($urandom), 0, 0);
      chk("t5_we", DW'(mem_we), DW'(1));
      chk("t5_addr3", DW'(mem_addr), DW'(3));
      do_clr();
      chk("t5_cnt", DW'(word_cnt), DW'(0));
      chk("t5_addr0", DW'(mem_addr), DW'(0));

      // rst with 9 bytes assembled
      for (int i = 0; i < 9; i++) tick(1, 8'($urandom), 0, 0);
      #2 rst = 1;
      model_reset();
      #1 chk("t6_ready_rst", DW'(s_ready), DW'(0));
      repeat (2) @(posedge clk);
      #1 rst = 0;
      // rst during a presented write
      for (int i = 0; i < 16; i++) tick(1, 8'($urandom), 0, 0);
      #2 rst = 1;
      model_reset();
      #1 chk("t6_we_rst", DW'(mem_we), DW'(0));
      repeat (2) @(posedge clk);
      #1 rst = 0;
      for (int i = 0; i < 16; i++) tick(1, 8'($urandom), 0, 0);
      chk("t6_addr", DW'(mem_addr), DW'(0));
      chk("t6_we", DW'(mem_we), DW'(1));

      // Random mix of gaps, stream ends and occasional clr
      do_clr();
      for (int i = 0; i < 1500; i++)
         tick(($urandom % 3) != 0, 8'($urandom), ($urandom % 8) == 0,
              ($urandom % 200) == 0);

      idle();
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
